inst_queue: RTL

- Decoupling buffer directly downstream of the dual-slot fetch stage.
- Accepts up to two 32-bit instructions per cycle from the 64-bit fetch pair, each tagged with its PC.
- Holds them in a circular FIFO and presents the two oldest to decode, which consumes 0, 1 or 2 per cycle.
- Absorbs decode stalls and discards contents on a redirect flush.

---
 rtl/core_pkg.sv | 16 +
 rtl/inst_queue_if.sv | 30 +++
 rtl/iq_storage.sv | 26 ++
 rtl/inst_queue.sv | 106 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Types and constants shared by the front-end blocks: entry layout of the
// instruction queue and the bubble encoding driven on empty decode slots.
package core_pkg;
  localparam int          INST_W      = 32;
  localparam int          FETCH_WIDTH = 2;
  localparam logic [31:0] BUBBLE_INST = 32'h0;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
endpackage

// File: rtl/inst_queue_if.sv
// Fetch-pair in / decode-pair out bundle of the instruction queue.
interface inst_queue_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             flush_i;
  logic [1:0]       fetch_valid_i;
  logic [31:0]      fetch_pc_i;
  logic [31:0]      fetch_inst_0_i;
  logic [31:0]      fetch_inst_1_i;
  logic             fetch_ready_o;
  logic [1:0]       dec_valid_o;
  logic [31:0]      dec_inst_0_o;
  logic [31:0]      dec_pc_0_o;
  logic [31:0]      dec_inst_1_o;
  logic [31:0]      dec_pc_1_o;
  logic [1:0]       dec_take_i;
  logic [CNT_W-1:0] count_o;

  modport slave (
    input  flush_i, fetch_valid_i, fetch_pc_i, fetch_inst_0_i, fetch_inst_1_i, dec_take_i,
    output fetch_ready_o, dec_valid_o, dec_inst_0_o, dec_pc_0_o, dec_inst_1_o, dec_pc_1_o,
           count_o
  );
  modport master (
    output flush_i, fetch_valid_i, fetch_pc_i, fetch_inst_0_i, fetch_inst_1_i, dec_take_i,
    input  fetch_ready_o, dec_valid_o, dec_inst_0_o, dec_pc_0_o, dec_inst_1_o, dec_pc_1_o,
           count_o
  );
endinterface

// File: rtl/iq_storage.sv
// Entry array of the instruction queue: two write ports, two async read ports.
// Not reset; validity is tracked by the pointers and count in the parent.
module iq_storage
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                                   clock_i,
  input  logic      [FETCH_WIDTH-1:0]            we_i,
  input  logic      [FETCH_WIDTH-1:0][PTR_W-1:0] waddr_i,
  input  iq_entry_t [FETCH_WIDTH-1:0]            wdata_i,
  input  logic      [FETCH_WIDTH-1:0][PTR_W-1:0] raddr_i,
  output iq_entry_t [FETCH_WIDTH-1:0]            rdata_o
);
  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (we_i[i]) mem_q[waddr_i[i]] <= wdata_i[i];
  end

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_rd
    assign rdata_o[g] = mem_q[raddr_i[g]];
  end
endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode.
// Define IQ_BYPASS_EN to forward an incoming pair straight to decode when empty.
module inst_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic         clock_i,
  input logic         reset_n_i,
  inst_queue_if.slave iq
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  iq_entry_t [FETCH_WIDTH-1:0]            pack, wdata, rdata;
  logic      [FETCH_WIDTH-1:0]            we;
  logic      [FETCH_WIDTH-1:0][PTR_W-1:0] waddr, raddr;
  logic [1:0] n_enq, n_take, n_deq, n_wr, skip;
  logic       ready, enq_fire, byp;

  assign ready = cnt_q <= CNT_W'(DEPTH - 2);

  always_comb begin
    pack[0]  = iq.fetch_valid_i[0] ? '{pc: iq.fetch_pc_i, inst: iq.fetch_inst_0_i}
                                   : '{pc: iq.fetch_pc_i + 32'd4, inst: iq.fetch_inst_1_i};
    pack[1]  = '{pc: iq.fetch_pc_i + 32'd4, inst: iq.fetch_inst_1_i};
    n_enq    = popcnt2(iq.fetch_valid_i);
    enq_fire = ready && (|iq.fetch_valid_i) && !iq.flush_i;
    n_take   = (iq.dec_take_i == 2'd3) ? 2'd2 : iq.dec_take_i;
    n_deq    = (CNT_W'(n_take) > cnt_q) ? cnt_q[1:0] : n_take;
`ifdef IQ_BYPASS_EN
    byp      = enq_fire && (cnt_q == '0);
`else
    byp      = 1'b0;
`endif
    // On bypass, decode consumes from the front of the packed pair; only the rest is stored
    skip     = byp ? ((n_take < n_enq) ? n_take : n_enq) : 2'd0;
    n_wr     = enq_fire ? n_enq - skip : 2'd0;
    wdata[0] = (skip == 2'd0) ? pack[0] : pack[1];
    wdata[1] = pack[1];
    we       = {n_wr == 2'd2, n_wr != 2'd0};
    waddr[0] = tail_q;
    waddr[1] = tail_q + PTR_W'(1);
    raddr[0] = head_q;
    raddr[1] = head_q + PTR_W'(1);
    head_d   = head_q + PTR_W'(n_deq);
    tail_d   = tail_q + PTR_W'(n_wr);
    cnt_d    = cnt_q + CNT_W'(n_wr) - CNT_W'(n_deq);
    if (iq.flush_i) begin
      we     = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  iq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clock_i (clock_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    iq.dec_valid_o = {cnt_q >= CNT_W'(2), cnt_q >= CNT_W'(1)};
    iq.dec_pc_0_o   = rdata[0].pc;
    iq.dec_inst_0_o = rdata[0].inst;
    iq.dec_pc_1_o   = rdata[1].pc;
    iq.dec_inst_1_o = rdata[1].inst;
    if (byp) begin
      iq.dec_valid_o  = (n_enq == 2'd2) ? 2'b11 : 2'b01;
      iq.dec_pc_0_o   = pack[0].pc;
      iq.dec_inst_0_o = pack[0].inst;
      iq.dec_pc_1_o   = pack[1].pc;
      iq.dec_inst_1_o = pack[1].inst;
    end
    if (!iq.dec_valid_o[0]) begin
      iq.dec_pc_0_o   = 32'h0;
      iq.dec_inst_0_o = BUBBLE_INST;
    end
    if (!iq.dec_valid_o[1]) begin
      iq.dec_pc_1_o   = 32'h0;
      iq.dec_inst_1_o = BUBBLE_INST;
    end
  end

  assign iq.fetch_ready_o = ready;
  assign iq.count_o       = cnt_q;
endmodule
